// File: rtl/mips_pkg.sv
// Shared constants, state encoding and instruction classes for the
// multi-cycle MIPS control unit.
package mips_pkg;

  localparam logic [1:0] ALU_ZERO = 2'd0;
  localparam logic [1:0] ALU_ADD  = 2'd1;
  localparam logic [1:0] ALU_SUB  = 2'd2;
  localparam logic [1:0] ALU_OR   = 2'd3;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_HI   = 2'd2;

  localparam logic [1:0] NPC_SEQ  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_J    = 2'd2;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    C_RADD, C_RSUB, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_NOP, C_ILL
  } iclass_t;

endpackage

// File: rtl/mips_decode.sv
// Combinational instruction classifier: maps the IR word to the class the
// control FSM sequences on. The all-zero word is a nop, not an illegal R-type.
module mips_decode
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output iclass_t     cls
);

  logic [5:0] op, fn;
  assign op = instr[31:26];
  assign fn = instr[5:0];

  // opcode/funct lookup, nop checked first
  always_comb begin
    cls = C_ILL;
    if (instr == 32'd0) cls = C_NOP;
    else begin
      case (op)
        OP_RTYPE: begin
          if (fn == FN_ADDU)      cls = C_RADD;
          else if (fn == FN_SUBU) cls = C_RSUB;
          else                    cls = C_ILL;
        end
        OP_J:    cls = C_J;
        OP_BEQ:  cls = C_BEQ;
        OP_ORI:  cls = C_ORI;
        OP_LUI:  cls = C_LUI;
        OP_LW:   cls = C_LW;
        OP_SW:   cls = C_SW;
        default: cls = C_ILL;
      endcase
    end
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing, memory
// req/ack handshakes with a bounded wait counter, and datapath control decode.
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  npc_sel,
  output logic [1:0]  alu_op,
  output logic        alu_src_b,
  output logic [1:0]  ext_op,
  output logic        reg_we,
  output logic        reg_dst,
  output logic        wd_sel,
  output logic        err,
  output logic [2:0]  state
);

  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MEM_WAIT_MAX);

  state_t           state_q;
  logic [CNT_W-1:0] cnt;
  iclass_t          cls;

  mips_decode u_dec (.instr(instr), .cls(cls));

  // next-state sequencing; cnt restarts on every FETCH/MEM entry and on ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RST;
      cnt     <= '0;
    end else begin
      case (state_q)
        S_RST: begin
          state_q <= S_FETCH;
          cnt     <= '0;
        end
        S_FETCH: begin
          if (imem_ack) begin
            state_q <= S_DECODE;
            cnt     <= '0;
          end else if (cnt == WAIT_LIM) state_q <= S_ERR;
          else cnt <= cnt + 1'b1;
        end
        S_DECODE: begin
          cnt <= '0;
          case (cls)
            C_NOP, C_J: state_q <= S_FETCH;
            C_ILL:      state_q <= S_ERR;
            default:    state_q <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          cnt <= '0;
          case (cls)
            C_LW, C_SW: state_q <= S_MEM;
            C_BEQ:      state_q <= S_FETCH;
            default:    state_q <= S_WB;
          endcase
        end
        S_MEM: begin
          if (dmem_ack) begin
            state_q <= (cls == C_LW) ? S_WB : S_FETCH;
            cnt     <= '0;
          end else if (cnt == WAIT_LIM) state_q <= S_ERR;
          else cnt <= cnt + 1'b1;
        end
        S_WB: begin
          state_q <= S_FETCH;
          cnt     <= '0;
        end
        S_ERR:   state_q <= S_ERR;
        default: state_q <= S_ERR;
      endcase
    end
  end

  // datapath controls from state and class; fetch enables qualified by ack
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    npc_sel   = NPC_SEQ;
    alu_op    = ALU_ZERO;
    alu_src_b = 1'b0;
    ext_op    = EXT_ZERO;
    reg_we    = 1'b0;
    reg_dst   = 1'b0;
    wd_sel    = 1'b0;
    err       = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ack;
        pc_we    = imem_ack;
      end
      S_DECODE: begin
        if (cls == C_J) begin
          pc_we   = 1'b1;
          npc_sel = NPC_J;
        end
      end
      S_EXEC: begin
        case (cls)
          C_RADD: alu_op = ALU_ADD;
          C_RSUB: alu_op = ALU_SUB;
          C_ORI: begin
            alu_op = ALU_OR; alu_src_b = 1'b1; ext_op = EXT_ZERO;
          end
          C_LUI: begin
            alu_op = ALU_ADD; alu_src_b = 1'b1; ext_op = EXT_HI;
          end
          C_LW, C_SW: begin
            alu_op = ALU_ADD; alu_src_b = 1'b1; ext_op = EXT_SIGN;
          end
          C_BEQ: begin
            alu_op = ALU_SUB;
            if (alu_zero) begin
              pc_we   = 1'b1;
              npc_sel = NPC_BR;
            end
          end
          default: ;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls == C_SW);
      end
      S_WB: begin
        reg_we  = 1'b1;
        reg_dst = (cls == C_RADD) || (cls == C_RSUB);
        wd_sel  = (cls == C_LW);
      end
      S_ERR:   err = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: each instruction is expanded into its expected
// per-cycle output sequence from the instruction semantics and handshake
// timing, then replayed cycle by cycle against the controller.
module tb_mips_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        alu_zero, imem_ack, dmem_ack;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we;
  logic [1:0]  npc_sel, alu_op, ext_op;
  logic        alu_src_b, reg_we, reg_dst, wd_sel, err;
  logic [2:0]  state;

  int vectors = 0;
  int miscompares = 0;

  mips_mc_ctrl #(.MEM_WAIT_MAX(15), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .alu_zero(alu_zero),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we),
    .npc_sel(npc_sel), .alu_op(alu_op), .alu_src_b(alu_src_b),
    .ext_op(ext_op), .reg_we(reg_we), .reg_dst(reg_dst), .wd_sel(wd_sel),
    .err(err), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       imem_req, dmem_req, dmem_we, ir_we, pc_we;
    logic [1:0] npc_sel, alu_op;
    logic       alu_src_b;
    logic [1:0] ext_op;
    logic       reg_we, reg_dst, wd_sel, err;
    logic [2:0] state;
  } obs_t;

  typedef enum int {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_NOP, K_ILL} kind_t;

  typedef struct {
    obs_t e;
    logic ia, da, z;
  } step_t;

  step_t q[$];

  function automatic kind_t kind_of(input logic [31:0] w);
    logic [5:0] op, fn;
    op = w[31:26];
    fn = w[5:0];
    if (w == 32'd0) return K_NOP;
    case (op)
      6'h00:   return (fn == 6'h21) ? K_ADDU : (fn == 6'h23) ? K_SUBU : K_ILL;
      6'h0d:   return K_ORI;
      6'h0f:   return K_LUI;
      6'h23:   return K_LW;
      6'h2b:   return K_SW;
      6'h04:   return K_BEQ;
      6'h02:   return K_J;
      default: return K_ILL;
    endcase
  endfunction

  function automatic obs_t blank(input int st);
    obs_t o;
    o = '0;
    o.state = st[2:0];
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.imem_req = imem_req; o.dmem_req = dmem_req; o.dmem_we = dmem_we;
    o.ir_we = ir_we; o.pc_we = pc_we; o.npc_sel = npc_sel; o.alu_op = alu_op;
    o.alu_src_b = alu_src_b; o.ext_op = ext_op; o.reg_we = reg_we;
    o.reg_dst = reg_dst; o.wd_sel = wd_sel; o.err = err; o.state = state;
    return o;
  endfunction

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic check(input obs_t exp, input string tag);
    obs_t got;
    got = observe();
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h (state %0d vs %0d)", tag, got, exp, got.state, exp.state);
    end
  endtask

  task automatic push(input obs_t e, input logic ia, input logic da, input logic z);
    step_t s;
    s.e = e; s.ia = ia; s.da = da; s.z = z;
    q.push_back(s);
  endtask

  task automatic push_err(input int n);
    obs_t e;
    for (int i = 0; i < n; i++) begin
      e = blank(6); e.err = 1'b1;
      push(e, rb(), rb(), rb());
    end
  endtask

  // Expected cycle sequence. iw/dw: cycles of waiting before the ack (>15 = never).
  // Acks the current state does not request are randomised to show they are ignored.
  task automatic build(input logic [31:0] w, input int iw, input int dw, input logic z);
    kind_t k;
    obs_t e;
    k = kind_of(w);
    q.delete();
    for (int c = 0; c <= 15; c++) begin
      e = blank(1); e.imem_req = 1'b1;
      if (c == iw) begin e.ir_we = 1'b1; e.pc_we = 1'b1; end
      push(e, (c == iw), rb(), rb());
      if (c == iw) break;
    end
    if (iw > 15) begin push_err(3); return; end
    e = blank(2);
    if (k == K_J) begin e.pc_we = 1'b1; e.npc_sel = 2'd2; end
    push(e, rb(), rb(), rb());
    if (k == K_NOP || k == K_J) return;
    if (k == K_ILL) begin push_err(3); return; end
    e = blank(3);
    case (k)
      K_ADDU: e.alu_op = 2'd1;
      K_SUBU: e.alu_op = 2'd2;
      K_ORI:  begin e.alu_op = 2'd3; e.alu_src_b = 1'b1; e.ext_op = 2'd0; end
      K_LUI:  begin e.alu_op = 2'd1; e.alu_src_b = 1'b1; e.ext_op = 2'd2; end
      K_LW, K_SW: begin e.alu_op = 2'd1; e.alu_src_b = 1'b1; e.ext_op = 2'd1; end
      K_BEQ:  begin e.alu_op = 2'd2; if (z) begin e.pc_we = 1'b1; e.npc_sel = 2'd1; end end
      default: ;
    endcase
    push(e, rb(), rb(), (k == K_BEQ) ? z : rb());
    if (k == K_BEQ) return;
    if (k == K_LW || k == K_SW) begin
      for (int c = 0; c <= 15; c++) begin
        e = blank(4); e.dmem_req = 1'b1; e.dmem_we = (k == K_SW);
        push(e, rb(), (c == dw), rb());
        if (c == dw) break;
      end
      if (dw > 15) begin push_err(3); return; end
      if (k == K_SW) return;
    end
    e = blank(5); e.reg_we = 1'b1;
    e.reg_dst = (k == K_ADDU || k == K_SUBU);
    e.wd_sel  = (k == K_LW);
    push(e, rb(), rb(), rb());
  endtask

  task automatic apply(input logic [31:0] w, input int maxsteps, input string tag);
    int n;
    n = (q.size() < maxsteps) ? q.size() : maxsteps;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) instr = w;
      imem_ack = q[i].ia;
      dmem_ack = q[i].da;
      alu_zero = q[i].z;
      #1 check(q[i].e, tag);
    end
  endtask

  task automatic do_reset(input logic late_ack, input string tag);
    #2 rst_n = 1'b0;
    #1 check(blank(0), {tag, "_async"});
    @(negedge clk);
    imem_ack = 1'b0;
    dmem_ack = late_ack;
    rst_n = 1'b1;
    #1 check(blank(0), {tag, "_rst"});
  endtask

  task automatic run(input logic [31:0] w, input int iw, input int dw, input logic z, input string tag);
    build(w, iw, dw, z);
    apply(w, q.size(), tag);
    if (q[q.size()-1].e.state == 3'd6) do_reset(1'b0, tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] r, w;
    int sel;
    rst_n = 1'b0; instr = 32'd0; alu_zero = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    #1 check(blank(0), "por");
    do_reset(1'b0, "init");

    run(32'h00851021, 0, 0, 1'b0, "addu");
    run(32'h8C820004, 0, 3, 1'b0, "lw_wait3");
    run(32'h10850003, 0, 0, 1'b1, "beq_taken");
    run(32'h10850003, 1, 0, 1'b0, "beq_not");
    run(32'h00A41823, 2, 0, 1'b0, "subu");
    run(32'h3482FFFF, 0, 0, 1'b0, "ori");
    run(32'h3C031234, 0, 0, 1'b0, "lui");
    run(32'h08000040, 0, 0, 1'b0, "j");
    run(32'h00000000, 0, 0, 1'b0, "nop");
    run(32'hAC820008, 0, 15, 1'b0, "sw_ack_at_limit");
    run(32'h00851021, 15, 0, 1'b0, "fetch_ack_at_limit");
    run(32'hAC820008, 0, 99, 1'b0, "sw_timeout");
    run(32'h00851021, 99, 0, 1'b0, "fetch_timeout");
    run(32'hFC000000, 0, 0, 1'b0, "illegal_op");
    run(32'h00851020, 0, 0, 1'b0, "illegal_funct");

    // reset mid-MEM of a sw, then a stale dmem_ack while restarting
    build(32'hAC820008, 0, 99, 1'b0);
    apply(32'hAC820008, 5, "sw_mid");
    do_reset(1'b1, "sw_mid");
    run(32'h00851021, 0, 0, 1'b0, "after_mid_reset");

    for (int n = 0; n < 40; n++) begin
      r = $urandom();
      sel = $urandom_range(0, 9);
      case (sel)
        0: w = {6'h00, r[25:6], 6'h21};
        1: w = {6'h00, r[25:6], 6'h23};
        2: w = {6'h0d, r[25:0]};
        3: w = {6'h0f, r[25:0]};
        4: w = {6'h23, r[25:0]};
        5: w = {6'h2b, r[25:0]};
        6: w = {6'h04, r[25:0]};
        7: w = {6'h02, r[25:0]};
        8: w = 32'd0;
        default: w = r[31] ? {6'h3f, r[25:0]} : {6'h00, r[25:6], 6'h20};
      endcase
      run(w, $urandom_range(0, 3), $urandom_range(0, 3), rb(), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
